// File: rtl/min_weight_solution_sink_if.sv
// AXI-Stream bundle carrying solution bit-vector beats.
// Slave side only drives tready.
interface axi_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/min_weight_solution_sink.sv
// Reassembles streamed GF(2) solutions and keeps the minimum-weight one.
// Reports best vector, its weight and the solution count on the final beat.
module min_weight_solution_sink #(
    parameter int MAX_VEC_LENGTH = 16,
    parameter int AXI_DATA_WIDTH = 8,
    parameter int COUNT_W        = 16,
    localparam int LEN_W     = $clog2(MAX_VEC_LENGTH + 1),
    localparam int BEATS_MAX = (MAX_VEC_LENGTH + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LEN_W-1:0]          vec_length,
    input  logic                      start,
    axi_stream_if.slave               solution_stream,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [MAX_VEC_LENGTH-1:0] best_vec,
    output logic [LEN_W-1:0]          best_weight,
    output logic [COUNT_W-1:0]        solution_count
);

    localparam int BUF_W = BEATS_MAX * AXI_DATA_WIDTH;
    localparam int IDX_W = $clog2(BEATS_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_EVAL,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [IDX_W-1:0]          beat_idx_q, beat_idx_d;
    logic [BUF_W-1:0]          buf_q, buf_d;
    logic                      last_q, last_d;
    logic [MAX_VEC_LENGTH-1:0] best_vec_q, best_vec_d;
    logic [LEN_W-1:0]          best_weight_q, best_weight_d;
    logic [COUNT_W-1:0]        count_q, count_d;
    logic                      error_q, error_d;
    logic                      tready_q, tready_d;

    logic [IDX_W-1:0]          beats_need;
    logic [MAX_VEC_LENGTH-1:0] vec_masked;
    logic [LEN_W-1:0]          weight;
    logic                      accept;
    logic                      len_bad;

    // Assembled vector with bits at and above the latched length cleared
    always_comb begin
        beats_need = IDX_W'((int'(len_q) + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH);
        vec_masked = '0;
        weight     = '0;
        for (int i = 0; i < MAX_VEC_LENGTH; i++) begin
            vec_masked[i] = buf_q[i] & (i < int'(len_q));
        end
        for (int i = 0; i < MAX_VEC_LENGTH; i++) begin
            weight = weight + LEN_W'(vec_masked[i]);
        end
    end

    assign accept  = solution_stream.tvalid && tready_q;
    assign len_bad = (vec_length == '0) || (int'(vec_length) > MAX_VEC_LENGTH);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        beat_idx_d    = beat_idx_q;
        buf_d         = buf_q;
        last_d        = last_q;
        best_vec_d    = best_vec_q;
        best_weight_d = best_weight_q;
        count_d       = count_q;
        error_d       = error_q;
        tready_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d         = vec_length;
                    beat_idx_d    = '0;
                    buf_d         = '0;
                    last_d        = 1'b0;
                    count_d       = '0;
                    error_d       = 1'b0;
                    best_vec_d    = '0;
                    best_weight_d = '1;
                    if (len_bad) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tready_d = 1'b1;
                        state_d  = S_RECV;
                    end
                end
            end
            S_RECV: begin
                tready_d = 1'b1;
                if (accept) begin
                    buf_d[int'(beat_idx_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] =
                        solution_stream.tdata;
                    if (beat_idx_q == beats_need - 1'b1) begin
                        beat_idx_d = '0;
                        last_d     = solution_stream.tlast;
                        tready_d   = 1'b0;
                        state_d    = S_EVAL;
                    end else if (solution_stream.tlast) begin
                        // Stream ended mid-vector: drop the partial vector
                        beat_idx_d = '0;
                        buf_d      = '0;
                        error_d    = 1'b1;
                        tready_d   = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                end
            end
            S_EVAL: begin
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
                if (weight < best_weight_q) begin
                    best_vec_d    = vec_masked;
                    best_weight_d = weight;
                end
                if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    tready_d = 1'b1;
                    state_d  = S_RECV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            beat_idx_q    <= '0;
            buf_q         <= '0;
            last_q        <= 1'b0;
            best_vec_q    <= '0;
            best_weight_q <= '0;
            count_q       <= '0;
            error_q       <= 1'b0;
            tready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            beat_idx_q    <= beat_idx_d;
            buf_q         <= buf_d;
            last_q        <= last_d;
            best_vec_q    <= best_vec_d;
            best_weight_q <= best_weight_d;
            count_q       <= count_d;
            error_q       <= error_d;
            tready_q      <= tready_d;
        end
    end

    assign solution_stream.tready = tready_q;
    assign busy                   = (state_q != S_IDLE);
    assign done                   = (state_q == S_DONE);
    assign error                  = error_q;
    assign best_vec               = best_vec_q;
    assign best_weight            = best_weight_q;
    assign solution_count         = count_q;

endmodule

// File: tb/tb_min_weight_solution_sink.sv
// Directed bench for min_weight_solution_sink with a vector-level model.
// Checks results on every done pulse plus hand-computed literals.
module tb_min_weight_solution_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  vec_length;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] best_vec;
    logic [4:0]  best_weight;
    logic [15:0] solution_count;

    axi_stream_if #(.DATA_W(8)) s ();

    min_weight_solution_sink #(
        .MAX_VEC_LENGTH(16),
        .AXI_DATA_WIDTH(8),
        .COUNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vec_length(vec_length),
        .start(start),
        .solution_stream(s),
        .busy(busy),
        .done(done),
        .error(error),
        .best_vec(best_vec),
        .best_weight(best_weight),
        .solution_count(solution_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_vec;
    logic [4:0]  exp_w;
    logic [15:0] exp_cnt;
    logic        exp_err;
    bit          armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected result of a run: complete vectors in arrival order
    task automatic model(input int len, input int vecs[$], input bit err);
        int mask;
        int bw;
        int bv;
        if (len == 0 || len > 16) begin
            exp_vec = 16'h0;
            exp_w   = 5'h1f;
            exp_cnt = 16'h0;
            exp_err = 1'b1;
        end else begin
            mask = (1 << len) - 1;
            bw   = 31;
            bv   = 0;
            foreach (vecs[i]) begin
                if ($countones(vecs[i] & mask) < bw) begin
                    bw = $countones(vecs[i] & mask);
                    bv = vecs[i] & mask;
                end
            end
            exp_vec = 16'(bv);
            exp_w   = 5'(bw);
            exp_cnt = 16'(vecs.size());
            exp_err = err;
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (!armed) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got 1 expected 0 at %0t", $time);
            end else begin
                chk("done_best_vec", best_vec, exp_vec);
                chk("done_best_weight", best_weight, exp_w);
                chk("done_count", solution_count, exp_cnt);
                chk("done_error", error, exp_err);
                armed = 1'b0;
            end
        end
    end

    task automatic do_start(input int len);
        start      = 1'b1;
        vec_length = 5'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input int gap);
        int t = 0;
        s.tvalid = 1'b0;
        repeat (gap) @(negedge clk);
        s.tdata  = d;
        s.tlast  = last;
        s.tvalid = 1'b1;
        while (s.tready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout got tready %0b expected 1", s.tready);
        end
        @(negedge clk);
        s.tvalid = 1'b0;
        s.tlast  = 1'b0;
    endtask

    task automatic send_stream(input int len, input int vecs[$],
                               input int early_k, input int max_gap);
        int beats = (len + 7) / 8;
        int n = vecs.size();
        for (int v = 0; v < n; v++) begin
            for (int b = 0; b < beats; b++) begin
                bit fin_vec = (b == beats - 1);
                bit early = (v == early_k) && (b == 0);
                bit fin_stream = early || ((v == n - 1) && fin_vec);
                int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
                send_beat(8'((vecs[v] >> (8 * b)) & 255), fin_stream, gap);
                if (early) begin
                    chk("early_done_next", done, 1);
                    return;
                end
                if (fin_vec) begin
                    chk("eval_tready", s.tready, 0);
                    chk("eval_busy", busy, 1);
                    if (fin_stream) begin
                        chk("done_t1", done, 0);
                        @(negedge clk);
                        chk("done_t2", done, 1);
                    end
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_tready"}, s.tready, 0);
        chk({tag, "_best_vec"}, best_vec, 0);
        chk({tag, "_best_weight"}, best_weight, 0);
        chk({tag, "_count"}, solution_count, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int q[$];
        rst        = 1'b1;
        start      = 1'b0;
        vec_length = '0;
        s.tvalid   = 1'b0;
        s.tdata    = '0;
        s.tlast    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // Minimum selection, tie keeps earlier vector
        q = '{32'h3FF, 32'h005, 32'h300};
        model(10, q, 1'b0);
        armed = 1'b1;
        do_start(10);
        chk("start_tready", s.tready, 1);
        send_stream(10, q, -1, 0);
        chk("min_lit_vec", best_vec, 16'h0005);
        chk("min_lit_weight", best_weight, 2);
        chk("min_lit_count", solution_count, 3);
        chk("min_lit_error", error, 0);
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Masking of bits beyond vec_length
        q = '{32'hFF};
        model(5, q, 1'b0);
        armed = 1'b1;
        do_start(5);
        send_stream(5, q, -1, 0);
        chk("mask_lit_vec", best_vec, 16'h001F);
        chk("mask_lit_weight", best_weight, 5);
        chk("mask_lit_count", solution_count, 1);
        repeat (2) @(negedge clk);

        // Gap-free then gapped run, start held high while busy
        q = '{32'hFFFF, 32'hF801, 32'h00F0, 32'h0102};
        model(12, q, 1'b0);
        armed = 1'b1;
        do_start(12);
        send_stream(12, q, -1, 0);
        chk("gapfree_lit_vec", best_vec, 16'h0801);
        repeat (2) @(negedge clk);
        model(12, q, 1'b0);
        armed = 1'b1;
        do_start(12);
        start      = 1'b1;
        vec_length = 5'd3;
        send_stream(12, q, -1, 3);
        start = 1'b0;
        chk("gap_lit_vec", best_vec, 16'h0801);
        chk("gap_lit_weight", best_weight, 2);
        chk("gap_lit_count", solution_count, 4);
        repeat (3) @(negedge clk);
        chk("gap_idle_after", busy, 0);

        // Early tlast on first beat of second vector
        q = '{32'h0A5};
        model(12, q, 1'b1);
        armed = 1'b1;
        do_start(12);
        q = '{32'h0A5, 32'h0FF};
        send_stream(12, q, 1, 0);
        chk("early_lit_error", error, 1);
        chk("early_lit_count", solution_count, 1);
        chk("early_lit_vec", best_vec, 16'h00A5);
        chk("early_lit_weight", best_weight, 4);
        repeat (2) @(negedge clk);

        // Illegal lengths finish on the next cycle
        q = '{};
        model(0, q, 1'b1);
        armed = 1'b1;
        do_start(0);
        chk("len0_done", done, 1);
        chk("len0_error", error, 1);
        chk("len0_count", solution_count, 0);
        repeat (2) @(negedge clk);
        model(17, q, 1'b1);
        armed = 1'b1;
        do_start(17);
        chk("len17_done", done, 1);
        repeat (2) @(negedge clk);

        // Reset mid-vector aborts without done
        armed = 1'b0;
        do_start(12);
        send_beat(8'h12, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midrst");
        repeat (5) @(negedge clk);
        chk("midrst_still_idle", busy, 0);
        q = '{32'h13};
        model(5, q, 1'b0);
        armed = 1'b1;
        do_start(5);
        send_stream(5, q, -1, 0);
        chk("fresh_lit_vec", best_vec, 16'h0013);
        chk("fresh_lit_weight", best_weight, 3);
        repeat (3) @(negedge clk);
        chk("all_done_seen", armed, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/min_weight_solution_sink.md
# min_weight_solution_sink

Receiving end of the solution stream produced by the GF(2) solution enumerator. It consumes the bit-vector solutions arriving over an AXI-Stream slave and reassembles each one from `AXI_DATA_WIDTH`-bit beats. It tracks the minimum-Hamming-weight solution seen, which is the minimum button-press count, and reports it when the stream's final beat (`tlast`) arrives. It sits directly downstream of the enumerator and feeds the per-machine result accumulator.

## Interface
Parameters:
- `MAX_VEC_LENGTH`, 16: maximum solution length in bits (variables).
- `AXI_DATA_WIDTH`, 8: stream beat width.
- `COUNT_W`, 16: width of the solution counter.
- Derived: `LEN_W = clog2(MAX_VEC_LENGTH+1)`; `BEATS_MAX = ceil(MAX_VEC_LENGTH/AXI_DATA_WIDTH)`.

Ports:
- `clk`, in, 1: the single clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `vec_length`, in, `LEN_W`: bits per solution vector. Sampled on `start`.
- `start`, in, 1: arms the block for one stream. Honoured only in IDLE.
- `solution_stream`, `axi_stream_if.slave`: carries `tdata[AXI_DATA_WIDTH]`, `tvalid`, `tready`, `tlast`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when results become valid.
- `error`, out, 1: protocol or length error on the last run. Held until the next `start`.
- `best_vec`, out, `MAX_VEC_LENGTH`: minimum-weight solution. Bits at and above `vec_length` are 0.
- `best_weight`, out, `LEN_W`: popcount of `best_vec`.
- `solution_count`, out, `COUNT_W`: number of complete vectors received. Saturates at all-ones.

## Operation
- States and transitions:
  - IDLE: `start` → RECV.
  - RECV: last beat of a vector accepted → EVAL.
  - EVAL: to RECV, or to DONE if that beat had `tlast`.
  - DONE: always returns to IDLE after 1 cycle.
- On `start` in IDLE:
  - latch `vec_length`;
  - clear `beat_idx`, `solution_count`, `error` and `best_vec`;
  - set `best_weight` to all-ones;
  - go to RECV.
- `vec_length == 0` or `vec_length > MAX_VEC_LENGTH` on `start`: go straight to DONE with `error=1`, `solution_count=0`; no beats consumed.
- Vector framing:
  - each vector is `ceil(vec_length/AXI_DATA_WIDTH)` beats;
  - beat k carries vector bits `[k*W +: W]`, least-significant beat first;
  - last-beat bits at positions ≥ `vec_length` are ignored (masked to 0).
- A beat is accepted only when `tvalid && tready`. Partial assembly is held across `tvalid` gaps.
- `tlast` marks the final beat of the final vector.
  - `tlast` on a beat that is not a vector's last beat: set `error`, discard the partial vector, go to DONE. That beat is consumed.
- EVAL:
  - popcount the assembled vector and increment `solution_count` (saturating);
  - if the weight is strictly less than `best_weight`, update `best_vec` and `best_weight`. On ties the earlier vector is kept.
- `start` while `busy` is ignored.
- `best_*`, `solution_count` and `error` are held stable from DONE until the next accepted `start`.

## Timing
- Reset values:
  - state IDLE;
  - `tready=0`, `busy=0`, `done=0`, `error=0`;
  - `best_vec=0`, `best_weight=0`, `solution_count=0`.
- `tready` is high in RECV only, registered: it asserts the cycle after `start` and deasserts the cycle after the final beat of each vector.
- Final beat accepted in cycle t:
  - EVAL in t+1, with `tready=0`;
  - RECV resumes in t+2, or DONE in t+2 with `done=1` in t+2.
- Outputs are valid in the same cycle as `done`.
- Throughput: one vector per `beats+1` cycles.
- `rst` mid-stream aborts immediately to reset values. No `done` pulse is emitted.

## Test plan
- Minimum selection: `W=8`, `MAX_VEC_LENGTH=16`, `vec_length=10`; vectors 0x3FF, 0x005, 0x300 (last with `tlast`). Expect `best_vec=0x005`, `best_weight=2`, `solution_count=3`, `error=0`, and `done` exactly 2 cycles after the last beat.
- Masking: `vec_length=5`, single beat `tdata=0xFF` with `tlast`. Expect `best_vec=0x1F`, `best_weight=5`, count 1.
- Back-pressure/gaps: `vec_length=12` with random `tvalid` gaps between the two beats of each of 4 vectors. Results must match the gap-free run; `tready` must be 0 in each EVAL cycle.
- Early `tlast`: `vec_length=12`, `tlast` on the first beat of the second vector. Expect `error=1`, `solution_count=1`, and `best_*` from the first vector.
- `start` ignored while `busy`; `vec_length=0` on `start`. Expect `done` on the next cycle with `error=1` and count 0.
- `rst` asserted mid-vector. Expect all outputs at reset values the next cycle and no `done`; a fresh `start` then completes normally.
